spiker_frame_loader: RTL

Parametrised, double-buffered capture stage between the spiker adapter register file and the spiking core. Assembles N_REG register words into one spike frame, either in a single cycle (bulk) or WORDS_PER_BEAT words per cycle (sequential). The frame is presented to the core over a valid/ready handshake. A shadow buffer lets the next frame fill while the core still holds the current one; frames are counted and overruns are flagged.

---
 rtl/spiker_loader_pkg.sv | 13 +
 rtl/spiker_frame_slot.sv | 53 +++++
 rtl/spiker_frame_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spiker_loader_pkg.sv
// Shared types for the spiker frame loader: FSM state encoding and capture-mode constants.
package spiker_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } loader_state_e;

  localparam logic MODE_BULK = 1'b0;
  localparam logic MODE_SEQ  = 1'b1;

endpackage

// File: rtl/spiker_frame_slot.sv
// Output slot of the frame loader: holds the frame presented to the core,
// runs the valid/ready handshake and counts consumed frames.
module spiker_frame_slot #(
  parameter int DATA_W = 800,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              free_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hs;

  assign w_hs    = r_valid & ready_i;
  // The slot can take a new frame when empty or when the current one leaves this cycle.
  assign free_o  = ~r_valid | ready_i;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign cnt_o   = r_cnt;

  // Buffer, valid flag and handshake counter; a load on a handshake cycle keeps valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      r_valid <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (w_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (load_i) begin
        r_data  <= data_i;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spiker_frame_loader.sv
// Double-buffered spike frame capture: a shadow buffer is filled from the
// register file (all at once or beat by beat) and handed to the output slot.
module spiker_frame_loader
  import spiker_loader_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int N_REG          = 25,
  parameter int N_SPIKES       = 784,
  parameter int WORDS_PER_BEAT = 5,
  parameter int CNT_W          = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REG*WIDTH-1:0]   words_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     clr_i,
  output logic                     busy_o,
  output logic                     frame_valid_o,
  input  logic                     frame_ready_i,
  output logic [N_SPIKES-1:0]      frame_o,
  output logic [CNT_W-1:0]         frame_cnt_o,
  output logic                     overrun_o
);

  localparam int BUF_W      = N_REG * WIDTH;
  localparam int BEATS      = N_REG / WORDS_PER_BEAT;
  localparam int BEAT_W     = WORDS_PER_BEAT * WIDTH;
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(BEATS - 1);

  if (N_SPIKES > N_REG * WIDTH) begin : g_chk_spikes
    $error("spiker_frame_loader: N_SPIKES exceeds N_REG*WIDTH");
  end
  if ((N_REG % WORDS_PER_BEAT) != 0) begin : g_chk_beats
    $error("spiker_frame_loader: WORDS_PER_BEAT must divide N_REG");
  end

  loader_state_e           r_state;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic [BUF_W-1:0]        r_shadow;
  logic                    r_busy;
  logic                    r_overrun;
  logic                    w_slot_free;
  logic                    w_load;
  logic [BUF_W-1:0]        w_out_buf;

  // Hand the shadow frame over in PEND as soon as the slot can take it; clear wins.
  assign w_load = (r_state == PEND) & w_slot_free & ~clr_i;

  // Capture FSM: fills the shadow buffer, tracks beats, flags starts that arrive while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_beat_cnt <= {BEAT_CNT_W{1'b0}};
      r_shadow   <= {BUF_W{1'b0}};
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (clr_i) begin
      r_state    <= IDLE;
      r_beat_cnt <= {BEAT_CNT_W{1'b0}};
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (mode_i == MODE_BULK) begin
              r_shadow <= words_i;
              r_state  <= PEND;
            end else begin
              r_shadow[BEAT_W-1:0] <= words_i[BEAT_W-1:0];
              r_beat_cnt           <= BEAT_CNT_W'(1);
              r_state              <= (BEATS == 1) ? PEND : FILL;
            end
          end
        end
        FILL: begin
          if (start_i) begin
            r_overrun <= 1'b1;
          end
          for (int b = 0; b < BEATS; b++) begin
            if (r_beat_cnt == BEAT_CNT_W'(b)) begin
              r_shadow[b*BEAT_W +: BEAT_W] <= words_i[b*BEAT_W +: BEAT_W];
            end
          end
          r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
          if (r_beat_cnt == BEAT_LAST) begin
            r_state <= PEND;
          end
        end
        PEND: begin
          if (start_i) begin
            r_overrun <= 1'b1;
          end
          if (w_slot_free) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  spiker_frame_slot #(
    .DATA_W (BUF_W),
    .CNT_W  (CNT_W)
  ) u_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .load_i  (w_load),
    .data_i  (r_shadow),
    .ready_i (frame_ready_i),
    .valid_o (frame_valid_o),
    .data_o  (w_out_buf),
    .cnt_o   (frame_cnt_o),
    .free_o  (w_slot_free)
  );

  // Bits above N_SPIKES are carried in the buffers but never reach the core.
  if (BUF_W > N_SPIKES) begin : g_drop
    logic w_unused_upper;
    assign w_unused_upper = ^w_out_buf[BUF_W-1:N_SPIKES];
  end

  assign frame_o   = w_out_buf[N_SPIKES-1:0];
  assign busy_o    = r_busy;
  assign overrun_o = r_overrun;

endmodule
